// File: rtl/adc_sample_packer.sv
// adc_sample_packer: decimates 12-bit ADC samples and frames each kept
// sample as a 3-byte packet (sync, {err,seq,data[11:8]}, data[7:0]).
// Ports:
//   clk, rst_n       sample clock (ADC sck domain), async active-low reset
//   enable_i         allows new captures; low forces the decimator to 0
//   sample_i         12-bit ADC sample, qualified by sample_valid_i
//   sample_valid_i   one-cycle strobe marking a new sample
//   sample_error_i   ADC frame error flag, qualified by sample_valid_i
//   fifo_full_i      UART TX FIFO full; stalls the packet in place
//   byte_o           byte presented to the FIFO (8'h00 when idle)
//   byte_wr_en_o     one byte written per high cycle
//   overrun_o        sticky; an eligible sample was dropped
//   busy_o           a packet is in progress
module adc_sample_packer #(
    parameter int unsigned DECIM     = 2000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [11:0] sample_i,
    input  logic        sample_valid_i,
    input  logic        sample_error_i,
    input  logic        fifo_full_i,
    output logic [7:0]  byte_o,
    output logic        byte_wr_en_o,
    output logic        overrun_o,
    output logic        busy_o
);

    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] dcnt;
    logic [11:0]   hold_data;
    logic          hold_err;
    logic [2:0]    seq;

    logic wr;
    logic eligible;
    logic capture;

    assign wr       = (state != IDLE) && !fifo_full_i;
    assign eligible = sample_valid_i && enable_i && (dcnt == '0);
    // A sample can only be taken when idle or when the LO byte leaves
    // this very cycle; anything else eligible is an overrun.
    assign capture  = eligible &&
                      ((state == IDLE) || ((state == LO) && wr));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (capture) state_nxt = HDR;
            HDR:  if (wr)      state_nxt = HI;
            HI:   if (wr)      state_nxt = LO;
            LO:   if (wr)      state_nxt = capture ? HDR : IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        byte_o       = 8'h00;
        byte_wr_en_o = wr;
        busy_o       = (state != IDLE);
        unique case (state)
            IDLE:    byte_o = 8'h00;
            HDR:     byte_o = SYNC_BYTE;
            HI:      byte_o = {hold_err, seq, hold_data[11:8]};
            LO:      byte_o = hold_data[7:0];
            default: byte_o = 8'h00;
        endcase
    end

    // Decimator, sample hold, sequence number and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt      <= '0;
            hold_data <= '0;
            hold_err  <= 1'b0;
            seq       <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (!enable_i) begin
                dcnt <= '0;
            end else if (sample_valid_i) begin
                dcnt <= (dcnt == DLAST) ? '0 : dcnt + DW'(1);
            end
            if (capture) begin
                hold_data <= sample_i;
                hold_err  <= sample_error_i;
            end
            if ((state == LO) && wr) begin
                seq <= seq + 3'd1;
            end
            if (eligible && !capture) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

Frames decimated 12-bit ADC samples into a 3-byte serial packet stream for the UART transmitter. It sits downstream of the ADC SPI interface, on that interface's `sck` clock domain, and feeds the UART TX byte FIFO. It replaces the current practice of writing only `adc_data[7:0]`. It adds decimation, a sync byte, a sequence number, the ADC error flag and FIFO back-pressure handling.

## Interface
- `DECIM`, default 2000: keep 1 of every `DECIM` valid samples; legal range 1..65535.
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.
- `clk` input 1: sample clock, the ADC `sck` domain.
- `rst_n` input 1: asynchronous active-low reset.
- `enable_i` input 1: when high, new samples may be captured.
- `sample_i` input 12: ADC sample, qualified by `sample_valid_i`.
- `sample_valid_i` input 1: one-cycle strobe marking a new sample.
- `sample_error_i` input 1: ADC frame error flag, qualified by `sample_valid_i`.
- `fifo_full_i` input 1: UART TX FIFO full.
- `byte_o` output 8: byte presented to the UART FIFO.
- `byte_wr_en_o` output 1: write strobe; one byte is written per high cycle.
- `overrun_o` output 1: sticky; set when an eligible sample is dropped.
- `busy_o` output 1: high whenever the FSM is not in IDLE.

## Operation
- Decimation counter `dcnt`, width max(1, $clog2(DECIM)).
  - Advances only on cycles with `sample_valid_i && enable_i`.
  - Counts 0..DECIM-1, then wraps to 0.
  - A valid sample is eligible when `dcnt == 0`, so the first valid sample after reset or after enable is captured.
  - When `enable_i` is low, `dcnt` is forced to 0.
  - With DECIM=1, every valid sample is eligible.
- Capture of an eligible sample latches:
  - `hold_data` ← `sample_i`
  - `hold_err` ← `sample_error_i`
  - FSM → HDR
- Packet layout, in order:
  - HDR = `SYNC_BYTE`
  - HI = {`hold_err`, `seq[2:0]`, `hold_data[11:8]`}
  - LO = `hold_data[7:0]`
- FSM states and transitions:
  - IDLE: `byte_wr_en_o`=0. Goes to HDR on capture.
  - HDR, HI and LO each emit their byte. The byte is written on a cycle with `!fifo_full_i`, and the FSM then advances to the next state. While `fifo_full_i` is high, the FSM holds its state and `byte_o` stays stable.
  - LO: after its write, goes to IDLE, or directly to HDR if an eligible sample arrives in that same cycle.
- `byte_wr_en_o` = (state != IDLE) && !`fifo_full_i`. It is combinational from state, so a full flag asserted in a cycle suppresses that cycle's write.
- `byte_o` is a combinational mux by state and reads 8'h00 in IDLE.
- `seq`: 3 bits, incremented on the LO write, wraps 7→0.
- Overrun:
  - If an eligible sample arrives while the FSM is in HDR or HI, or in LO without a write that cycle, the sample is dropped.
  - `overrun_o` is set and stays set until reset.
  - `hold_*` is unchanged, and `dcnt` still advances.
- Enable deassertion mid-packet: the current packet completes; no new captures occur.
- Reset mid-packet: the packet is abandoned immediately and no partial bytes are written afterwards.

## Timing
- Reset values:
  - `byte_wr_en_o`=0, `byte_o`=8'h00, `overrun_o`=0, `busy_o`=0
  - `seq`=0, `dcnt`=0, `hold_*`=0, state IDLE
- Latency: a sample captured at edge T puts the FSM in HDR from T+1, so the HDR write strobe is in cycle T+1 if not full.
- Minimum packet duration is 3 consecutive write cycles.
- Back-to-back packets are possible only when the next eligible sample coincides with the LO write; otherwise there are ≥1 IDLE cycles between packets.
- Throughput constraint for integration: 3 bytes × 10 bits per byte at the UART baud must fit within DECIM sample periods. This is not checked in RTL.

## Test plan
- Basic packet:
  - Stimulus: reset, `enable_i`=1, DECIM=4, valid sample 12'hABC with err=0.
  - Response: next three cycles write A5, 0A, BC; `seq`→1.
  - Stimulus continues: three more valids.
  - Response: no writes; the 5th valid produces A5, 1x, xx with `seq`=1 in HI.
- Back-pressure:
  - Stimulus: `fifo_full_i` high for 5 cycles starting at the HI cycle.
  - Response: HDR is written; no strobe for 5 cycles with `byte_o` held at the HI value; then HI and LO are written. Exactly 3 strobes total.
- Error flag and wrap:
  - Stimulus: DECIM=1, 9 packets, err=1 on the 9th.
  - Response: HI bytes carry `seq` 0..7, 0. The 9th HI byte has bit7=1 and bits6:4=000.
- Overrun:
  - Stimulus: DECIM=1, valid on consecutive cycles with `fifo_full_i` high.
  - Response: `overrun_o`=1 on the cycle after the second valid and stays set. The first packet's data is intact.
- Back-to-back:
  - Stimulus: DECIM=1, valids spaced exactly 3 cycles apart with the FIFO never full.
  - Response: continuous `byte_wr_en_o`=1, no IDLE gaps, `overrun_o`=0.
- Reset and enable:
  - Stimulus: assert `rst_n`=0 during HI.
  - Response: `byte_wr_en_o`=0 asynchronously; after release, state IDLE and the first valid is captured.
  - Stimulus: `enable_i`=0.
  - Response: no captures and `dcnt` held at 0.
